// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I decode constants: opcodes, ALU op codes, RF write-back source and
// immediate-format codes used by control_unit and alu_decoder.
package rv_ctrl_pkg;

    localparam int ALU_OP_W  = 4;
    localparam int IMM_SEL_W = 3;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b1001;

    localparam logic [1:0] RF_ALU  = 2'b00;
    localparam logic [1:0] RF_DMEM = 2'b01;
    localparam logic [1:0] RF_PC4  = 2'b10;

    localparam logic [IMM_SEL_W-1:0] IMM_NONE  = 3'b000;
    localparam logic [IMM_SEL_W-1:0] IMM_I     = 3'b001;
    localparam logic [IMM_SEL_W-1:0] IMM_S     = 3'b010;
    localparam logic [IMM_SEL_W-1:0] IMM_SHAMT = 3'b011;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op decode from funct3/funct7[5]; flags funct7[5] misuse on R-type.
import rv_ctrl_pkg::*;

module alu_decoder (
    input  logic [2:0]          funct3,
    input  logic                f7b5,
    input  logic                is_imm,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                legal
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = (f7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
        // Immediates carry no funct7 except the SRAI/SRLI selector, so only R-type can misuse it.
        legal = is_imm || !f7b5 || funct3 == 3'b000 || funct3 == 3'b101;
    end

endmodule

// File: rtl/control_unit.sv
// RV32I decode-stage control unit with a registered output stage.
// Define CU_ILLEGAL_DETECT_EN to add the registered 'illegal' output.
import rv_ctrl_pkg::*;

module control_unit (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    output logic                 Type_alu,
    output logic [2:0]           Type_dm,
    output logic [2:0]           salida_funct3,
    output logic                 store,
    output logic [ALU_OP_W-1:0]  controlALU,
    output logic [1:0]           controlRF,
    output logic                 we,
`ifdef CU_ILLEGAL_DETECT_EN
    output logic                 illegal,
`endif
    output logic [IMM_SEL_W-1:0] funct_imm
);

    logic [ALU_OP_W-1:0]  dec_op;
    logic                 dec_legal;

    logic                 n_type_alu;
    logic [2:0]           n_type_dm;
    logic                 n_store;
    logic [ALU_OP_W-1:0]  n_alu;
    logic [1:0]           n_rf;
    logic                 n_we;
    logic [IMM_SEL_W-1:0] n_imm;
    logic                 n_illegal;

    alu_decoder u_alu_dec (
        .funct3 (funct3),
        .f7b5   (funct7[5]),
        .is_imm (opcode == OP_IMM),
        .alu_op (dec_op),
        .legal  (dec_legal)
    );

    always_comb begin
        n_type_alu = 1'b0;
        n_type_dm  = 3'b000;
        n_store    = 1'b0;
        n_alu      = ALU_ADD;
        n_rf       = RF_ALU;
        n_we       = 1'b0;
        n_imm      = IMM_NONE;
        n_illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                n_alu     = dec_op;
                n_we      = 1'b1;
                n_illegal = !dec_legal || ((funct7 & 7'b1011111) != 7'b0);
            end
            OP_IMM: begin
                n_alu      = dec_op;
                n_type_alu = 1'b1;
                n_we       = 1'b1;
                n_imm      = (funct3 == 3'b001 || funct3 == 3'b101) ? IMM_SHAMT : IMM_I;
            end
            OP_LOAD: begin
                n_type_alu = 1'b1;
                n_imm      = IMM_I;
                n_type_dm  = funct3;
                n_we       = 1'b1;
                n_rf       = RF_DMEM;
                n_illegal  = funct3 == 3'b011 || funct3[2:1] == 2'b11;
            end
            OP_STORE: begin
                n_type_alu = 1'b1;
                n_imm      = IMM_S;
                n_type_dm  = funct3;
                n_store    = 1'b1;
                n_illegal  = funct3 > 3'b010;
            end
            OP_JALR: begin
                n_type_alu = 1'b1;
                n_imm      = IMM_I;
                n_we       = 1'b1;
                n_rf       = RF_PC4;
            end
            OP_SYSTEM: begin
                n_type_alu = 1'b1;
                n_imm      = IMM_I;
            end
            default: n_illegal = 1'b1;
        endcase
        // Illegal decodes collapse to a full NOP so nothing downstream can act on them.
        if (n_illegal) begin
            n_type_alu = 1'b0;
            n_type_dm  = 3'b000;
            n_store    = 1'b0;
            n_alu      = ALU_ADD;
            n_rf       = RF_ALU;
            n_we       = 1'b0;
            n_imm      = IMM_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Type_alu      <= 1'b0;
            Type_dm       <= 3'b000;
            salida_funct3 <= 3'b000;
            store         <= 1'b0;
            controlALU    <= '0;
            controlRF     <= 2'b00;
            we            <= 1'b0;
            funct_imm     <= '0;
`ifdef CU_ILLEGAL_DETECT_EN
            illegal       <= 1'b0;
`endif
        end else begin
            Type_alu      <= n_type_alu;
            Type_dm       <= n_type_dm;
            salida_funct3 <= funct3;
            store         <= n_store;
            controlALU    <= n_alu;
            controlRF     <= n_rf;
            we            <= n_we;
            funct_imm     <= n_imm;
`ifdef CU_ILLEGAL_DETECT_EN
            illegal       <= n_illegal;
`endif
        end
    end

`ifndef CU_ILLEGAL_DETECT_EN
    logic unused_illegal;
    assign unused_illegal = n_illegal;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: every-cycle compare against a behavioural decode model,
// plus directed literal checks and an asynchronous reset during a store.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Type_alu;
    logic [2:0] Type_dm;
    logic [2:0] salida_funct3;
    logic       store;
    logic [3:0] controlALU;
    logic [1:0] controlRF;
    logic       we;
    logic       illegal;
    logic [2:0] funct_imm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .Type_alu      (Type_alu),
        .Type_dm       (Type_dm),
        .salida_funct3 (salida_funct3),
        .store         (store),
        .controlALU    (controlALU),
        .controlRF     (controlRF),
        .we            (we),
`ifdef CU_ILLEGAL_DETECT_EN
        .illegal       (illegal),
`endif
        .funct_imm     (funct_imm)
    );

`ifndef CU_ILLEGAL_DETECT_EN
    assign illegal = 1'b0;
`endif

    // Packed view: {illegal, Type_alu, Type_dm, salida_funct3, store, controlALU, controlRF, we, funct_imm}
    function automatic logic [18:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int   base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic ok;
        int   alu;
        int   ta, dm, st, rf, w, imm;
        ok = 1; alu = 0; ta = 0; dm = 0; st = 0; rf = 0; w = 0; imm = 0;
        if (op == 7'h33) begin
            ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            alu = base[f3] + ((f7 == 7'h20) ? 1 : 0);
            w   = 1;
        end else if (op == 7'h13) begin
            alu = base[f3] + ((f3 == 3'd5 && f7[5]) ? 1 : 0);
            ta  = 1; w = 1;
            imm = (f3 == 3'd1 || f3 == 3'd5) ? 3 : 1;
        end else if (op == 7'h03) begin
            ok = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
            ta = 1; imm = 1; dm = f3; w = 1; rf = 1;
        end else if (op == 7'h23) begin
            ok = f3 <= 3'd2;
            ta = 1; imm = 2; dm = f3; st = 1;
        end else if (op == 7'h67) begin
            ta = 1; imm = 1; w = 1; rf = 2;
        end else if (op == 7'h73) begin
            ta = 1; imm = 1;
        end else begin
            ok = 0;
        end
        if (!ok) begin
            alu = 0; ta = 0; dm = 0; st = 0; rf = 0; w = 0; imm = 0;
        end
        return {!ok, ta[0], dm[2:0], f3, st[0], alu[3:0], rf[1:0], w[0], imm[2:0]};
    endfunction

    logic [18:0] exp_q;
    logic [18:0] act;
    logic [18:0] cmp_mask;

    assign act = {illegal, Type_alu, Type_dm, salida_funct3, store, controlALU, controlRF, we, funct_imm};
`ifdef CU_ILLEGAL_DETECT_EN
    assign cmp_mask = 19'h7ffff;
`else
    assign cmp_mask = 19'h3ffff;
`endif

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= '0;
        else        exp_q <= model(opcode, funct3, funct7);
    end

    always @(negedge clk) begin
        total++;
        if ((act & cmp_mask) !== (exp_q & cmp_mask)) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t op=%b f3=%b f7=%b actual=%h expected=%h",
                     $time, opcode, funct3, funct7, act & cmp_mask, exp_q & cmp_mask);
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Apply an instruction just after an edge; return just after the edge that registers it.
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset_all", {13'b0, act}, 32'd0);
        @(posedge clk); #4;
        check("reset_hold", {13'b0, act}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Model self-pins with hand-computed values.
        check("model_sub",   {13'b0, model(7'h33, 3'd0, 7'h20)}, {13'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 4'd1, 2'd0, 1'b1, 3'd0});
        check("model_srai",  {13'b0, model(7'h13, 3'd5, 7'h20)}, {13'b0, 1'b0, 1'b1, 3'd0, 3'd5, 1'b0, 4'd7, 2'd0, 1'b1, 3'd3});
        check("model_ldill", {13'b0, model(7'h03, 3'd7, 7'h00)}, {13'b0, 1'b1, 1'b0, 3'd0, 3'd7, 1'b0, 4'd0, 2'd0, 1'b0, 3'd0});

        do_instr(7'h33, 3'd0, 7'h00);
        check("add_alu", controlALU, 0); check("add_we", we, 1); check("add_talu", Type_alu, 0);
        do_instr(7'h33, 3'd0, 7'h20);
        check("sub_alu", controlALU, 1); check("sub_we", we, 1);
        do_instr(7'h13, 3'd0, 7'h00);
        check("addi_alu", controlALU, 0); check("addi_imm", funct_imm, 1); check("addi_talu", Type_alu, 1);
        do_instr(7'h13, 3'd5, 7'h20);
        check("srai_alu", controlALU, 7); check("srai_imm", funct_imm, 3);
        do_instr(7'h03, 3'd2, 7'h00);
        check("lw_dm", Type_dm, 2); check("lw_rf", controlRF, 1); check("lw_we", we, 1); check("lw_st", store, 0);
        do_instr(7'h23, 3'd2, 7'h00);
        check("sw_st", store, 1); check("sw_we", we, 0); check("sw_imm", funct_imm, 2);
        do_instr(7'h67, 3'd0, 7'h00);
        check("jalr_rf", controlRF, 2); check("jalr_we", we, 1);
        do_instr(7'h73, 3'd0, 7'h00);
        check("ecall_we", we, 0); check("ecall_st", store, 0); check("ecall_ill", illegal, 0);
        do_instr(7'h7f, 3'd4, 7'h00);
        check("bad_op_we", we, 0); check("bad_op_f3", salida_funct3, 4);
`ifdef CU_ILLEGAL_DETECT_EN
        check("bad_op_ill", illegal, 1);
`endif
        do_instr(7'h03, 3'd7, 7'h00);
        check("bad_ld_we", we, 0); check("bad_ld_dm", Type_dm, 0);
`ifdef CU_ILLEGAL_DETECT_EN
        check("bad_ld_ill", illegal, 1);
`endif

        // Asynchronous reset in the middle of a decoded store.
        do_instr(7'h23, 3'd1, 7'h00);
        check("rst_sw_pre", store, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_sw_async", {13'b0, act}, 32'd0);
        @(posedge clk); #1;
        check("rst_sw_hold", {13'b0, act}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_sw_first", store, 1);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [8];
            ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67, 7'h73, 7'h7f, 7'h00};
            opcode = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) opcode = 7'($urandom);
            funct3 = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       funct7 = 7'h00;
                1:       funct7 = 7'h20;
                default: funct7 = 7'($urandom);
            endcase
            if ($urandom_range(0, 39) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
